// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one apbmaster command port among NREQ requesters.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module apb_req_arbiter #(
   parameter int NREQ      = 4,
   parameter int addrwidth = 16,
   parameter int datawidth = 16
) (
   input  logic                      pclk,
   input  logic                      preset,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ-1:0]           req_write,
   input  logic [NREQ*addrwidth-1:0] req_addr,
   input  logic [NREQ*datawidth-1:0] req_wdata,
   output logic [NREQ-1:0]           req_grant,
   output logic [NREQ-1:0]           req_done,
   output logic [datawidth-1:0]      req_rdata,
   output logic                      m_start,
   output logic                      m_write,
   output logic [addrwidth-1:0]      m_addr,
   output logic [datawidth-1:0]      m_wdata,
   input  logic                      m_done,
   input  logic [datawidth-1:0]      m_rdata
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t               state_q, state_d;
   logic [NREQ-1:0]      grant_q, grant_d;
   logic [NREQ-1:0]      done_q, done_d;
   logic [datawidth-1:0] rdata_q, rdata_d;
   logic                 write_q, write_d;
   logic [addrwidth-1:0] addr_q, addr_d;
   logic [datawidth-1:0] wdata_q, wdata_d;

   logic [PW-1:0]        pick;
   logic [NREQ-1:0]      pick_oh;
   logic                 sel_write;
   logic [addrwidth-1:0] sel_addr;
   logic [datawidth-1:0] sel_wdata;

`ifdef ARB_FIXED_PRIO_EN
   always_comb begin
      pick = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) pick = PW'(i);
      end
   end
`else
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;

   // Scan starts just past the last winner so every requester gets a turn.
   function automatic logic [PW-1:0] rr_pick(
      input logic [NREQ-1:0] v,
      input logic [PW-1:0]   ptr
   );
      logic [PW-1:0] r;
      logic [PW-1:0] idx;
      logic          found;
      r     = ptr;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = PW'((int'(ptr) + k) % NREQ);
         if (!found && v[idx]) begin
            found = 1'b1;
            r     = idx;
         end
      end
      return r;
   endfunction

   always_comb pick = rr_pick(req_valid, rr_ptr_q);
`endif

   always_comb begin
      pick_oh   = '0;
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick == PW'(i)) begin
            pick_oh[i] = 1'b1;
            sel_write  = req_write[i];
            sel_addr   = req_addr[i*addrwidth +: addrwidth];
            sel_wdata  = req_wdata[i*datawidth +: datawidth];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      done_d  = '0;
      rdata_d = rdata_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_d = rr_ptr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (|req_valid) begin
               grant_d = pick_oh;
               write_d = sel_write;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
`ifndef ARB_FIXED_PRIO_EN
               rr_ptr_d = pick;
`endif
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (m_done) begin
               rdata_d = m_rdata;
               done_d  = grant_q;
               state_d = RESP;
            end
         end
         RESP: begin
            grant_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q <= IDLE;
         grant_q <= '0;
         done_q  <= '0;
         rdata_q <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

`ifndef ARB_FIXED_PRIO_EN
   always_ff @(posedge pclk) begin
      if (preset) rr_ptr_q <= PW'(NREQ - 1);
      else        rr_ptr_q <= rr_ptr_d;
   end
`endif

   assign req_grant = grant_q;
   assign req_done  = done_q;
   assign req_rdata = rdata_q;
   assign m_start   = (state_q == ISSUE);
   assign m_write   = write_q;
   assign m_addr    = addr_q;
   assign m_wdata   = wdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter with a behavioural apbmaster model.
// Build with ARB_FIXED_PRIO_EN to exercise the fixed-priority variant.
module tb_apb_req_arbiter;

   logic        pclk = 1'b0;
   logic        preset;
   logic [3:0]  req_valid, req_write, req_grant, req_done;
   logic [63:0] req_addr, req_wdata;
   logic [15:0] req_rdata, m_addr, m_wdata, m_rdata;
   logic        m_start, m_write, m_done;

   apb_req_arbiter #(.NREQ(4), .addrwidth(16), .datawidth(16)) dut (
      .pclk(pclk), .preset(preset),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_grant(req_grant), .req_done(req_done), .req_rdata(req_rdata),
      .m_start(m_start), .m_write(m_write), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_done(m_done), .m_rdata(m_rdata)
   );

   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   int comps = 0;
   int fails = 0;

   typedef struct {
      int          g;
      logic        w;
      logic [15:0] a;
      logic [15:0] d;
      int          cyc;
   } cmd_t;

   typedef struct {
      int          g;
      logic        chk;
      logic [15:0] rd;
      int          cyc;
   } rsp_t;

   cmd_t cq[$];
   rsp_t rq[$];

   int          slave_waits = 0;
   logic [15:0] slave_rdata = '0;
   int          xfers = 0;
   int          writes = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      comps++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic set_req(input int i, input logic w, input logic [15:0] a, input logic [15:0] d);
      req_write[i] = w;
      req_addr[i*16 +: 16] = a;
      req_wdata[i*16 +: 16] = d;
   endtask

   task automatic push_cmd(input int g, input logic w, input logic [15:0] a,
                           input logic [15:0] d, input int c);
      cmd_t e;
      e.g = g; e.w = w; e.a = a; e.d = d; e.cyc = c;
      cq.push_back(e);
   endtask

   task automatic push_rsp(input int g, input logic ck, input logic [15:0] rd, input int c);
      rsp_t e;
      e.g = g; e.chk = ck; e.rd = rd; e.cyc = c;
      rq.push_back(e);
   endtask

   task automatic wait_done(input logic [3:0] mask);
      for (int n = 0; n < 50; n++) begin
         @(negedge pclk);
         if ((req_done & mask) != 4'b0) return;
      end
      comps++;
      fails++;
      $display("FAIL wait_done: no req_done within 50 cycles, mask %b", mask);
   endtask

   task automatic do_reset();
      @(negedge pclk);
      preset = 1'b1;
      repeat (2) @(negedge pclk);
      preset = 1'b0;
      chk("rst_grant", 32'(req_grant), 32'h0);
      chk("rst_done", 32'(req_done), 32'h0);
      chk("rst_rdata", 32'(req_rdata), 32'h0);
      chk("rst_start", 32'(m_start), 32'h0);
      chk("rst_write", 32'(m_write), 32'h0);
      chk("rst_addr", 32'(m_addr), 32'h0);
      chk("rst_wdata", 32'(m_wdata), 32'h0);
   endtask

   // apbmaster model: done appears 3 cycles after start, plus wait states.
   initial begin
      int          cnt;
      logic [15:0] cap_addr;
      cnt = 0;
      cap_addr = '0;
      forever begin
         @(negedge pclk);
         if (preset) begin
            cnt = 0;
            m_done = 1'b0;
         end else begin
            m_done = 1'b0;
            if (cnt > 0) begin
               chk("addr_stable", 32'(m_addr), 32'(cap_addr));
               cnt--;
               if (cnt == 0) begin
                  m_done = 1'b1;
                  m_rdata = slave_rdata;
               end
            end
            if (m_start) begin
               cnt = 3 + slave_waits;
               cap_addr = m_addr;
               xfers++;
               if (m_write) writes++;
            end
         end
      end
   end

   // monitor
   initial begin
      cmd_t c;
      rsp_t r;
      forever begin
         @(negedge pclk);
         comps++;
         if ($countones(req_grant) > 1) begin
            fails++;
            $display("FAIL grant_onehot: got %b", req_grant);
         end
         if (m_start && !preset) begin
            if (cq.size() == 0) begin
               chk("unexpected_start", 32'(m_start), 32'h0);
            end else begin
               c = cq.pop_front();
               chk("grant", 32'(req_grant), 32'(1) << c.g);
               chk("m_write", 32'(m_write), 32'(c.w));
               chk("m_addr", 32'(m_addr), 32'(c.a));
               chk("m_wdata", 32'(m_wdata), 32'(c.d));
               if (c.cyc >= 0) chk("start_cycle", 32'(cyc), 32'(c.cyc));
            end
         end
         if (req_done != 4'b0) begin
            if (rq.size() == 0) begin
               chk("unexpected_done", 32'(req_done), 32'h0);
            end else begin
               r = rq.pop_front();
               chk("req_done", 32'(req_done), 32'(1) << r.g);
               if (r.chk) chk("req_rdata", 32'(req_rdata), 32'(r.rd));
               if (r.cyc >= 0) chk("done_cycle", 32'(cyc), 32'(r.cyc));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int gs[5];
      preset = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr = '0;
      req_wdata = '0;
      m_done = 1'b0;
      m_rdata = '0;
      do_reset();

      // single write from requester 0, no wait states
      set_req(0, 1'b1, 16'h0010, 16'hABCD);
      slave_waits = 0;
      push_cmd(0, 1'b1, 16'h0010, 16'hABCD, cyc + 1);
      push_rsp(0, 1'b0, 16'h0000, cyc + 5);
      req_valid = 4'b0001;
      wait_done(4'b0001);
      req_valid = 4'b0000;
      chk("xfers_t1", 32'(xfers), 32'd1);
      chk("writes_t1", 32'(writes), 32'd1);
      @(negedge pclk);

      // read from requester 2 with 3 wait states
      set_req(2, 1'b0, 16'h0020, 16'h0000);
      slave_waits = 3;
      slave_rdata = 16'h1234;
      push_cmd(2, 1'b0, 16'h0020, 16'h0000, cyc + 1);
      push_rsp(2, 1'b1, 16'h1234, cyc + 8);
      req_valid = 4'b0100;
      wait_done(4'b0100);
      req_valid = 4'b0000;
      chk("xfers_t2", 32'(xfers), 32'd2);
      chk("writes_t2", 32'(writes), 32'd1);
      do_reset();

`ifndef ARB_FIXED_PRIO_EN
      // all four requesting continuously
      for (int i = 0; i < 4; i++)
         set_req(i, (i % 2) == 1, 16'h0100 + 16'(i), 16'hC000 + 16'(i));
      slave_waits = 0;
      slave_rdata = 16'h5A5A;
      gs = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
         push_cmd(gs[k], (gs[k] % 2) == 1, 16'h0100 + 16'(gs[k]), 16'hC000 + 16'(gs[k]), -1);
         push_rsp(gs[k], (gs[k] % 2) == 0, 16'h5A5A, -1);
      end
      req_valid = 4'b1111;
      repeat (5) wait_done(4'b1111);
      chk("xfers_rr", 32'(xfers), 32'd7);

      // grant to 3, then 1010 must wrap to 1
      push_cmd(3, 1'b1, 16'h0103, 16'hC003, -1);
      push_rsp(3, 1'b0, 16'h0000, -1);
      req_valid = 4'b1000;
      wait_done(4'b1000);
      push_cmd(1, 1'b1, 16'h0101, 16'hC001, -1);
      push_rsp(1, 1'b0, 16'h0000, -1);
      push_cmd(3, 1'b1, 16'h0103, 16'hC003, -1);
      push_rsp(3, 1'b0, 16'h0000, -1);
      req_valid = 4'b1010;
      repeat (2) wait_done(4'b1010);
      req_valid = 4'b0000;
      chk("xfers_wrap", 32'(xfers), 32'd10);
      @(negedge pclk);
`endif

      // reset while the master is mid-transfer
      set_req(2, 1'b1, 16'h0030, 16'hBEEF);
      slave_waits = 5;
      push_cmd(2, 1'b1, 16'h0030, 16'hBEEF, cyc + 1);
      req_valid = 4'b0100;
      for (int n = 0; n < 10; n++) begin
         @(negedge pclk);
         if (m_start) break;
      end
      repeat (2) @(negedge pclk);
      preset = 1'b1;
      req_valid = 4'b0000;
      @(negedge pclk);
      chk("mid_rst_grant", 32'(req_grant), 32'h0);
      chk("mid_rst_done", 32'(req_done), 32'h0);
      chk("mid_rst_rdata", 32'(req_rdata), 32'h0);
      chk("mid_rst_start", 32'(m_start), 32'h0);
      chk("mid_rst_write", 32'(m_write), 32'h0);
      chk("mid_rst_addr", 32'(m_addr), 32'h0);
      chk("mid_rst_wdata", 32'(m_wdata), 32'h0);
      preset = 1'b0;
      repeat (8) @(negedge pclk);
      set_req(1, 1'b0, 16'h0040, 16'h0000);
      set_req(3, 1'b1, 16'h0050, 16'h1111);
      slave_waits = 0;
      slave_rdata = 16'h0F0F;
      push_cmd(1, 1'b0, 16'h0040, 16'h0000, cyc + 1);
      push_rsp(1, 1'b1, 16'h0F0F, cyc + 5);
      req_valid = 4'b1010;
      wait_done(4'b1010);
      req_valid = 4'b0000;
      do_reset();

      // two requesters held: priority policy
      set_req(1, 1'b1, 16'h0061, 16'h1001);
      set_req(2, 1'b1, 16'h0062, 16'h2002);
`ifdef ARB_FIXED_PRIO_EN
      for (int k = 0; k < 3; k++) begin
         push_cmd(1, 1'b1, 16'h0061, 16'h1001, -1);
         push_rsp(1, 1'b0, 16'h0000, -1);
      end
      req_valid = 4'b0110;
      repeat (3) wait_done(4'b0110);
      push_cmd(2, 1'b1, 16'h0062, 16'h2002, -1);
      push_rsp(2, 1'b0, 16'h0000, -1);
      req_valid = 4'b0100;
      wait_done(4'b0100);
`else
      push_cmd(1, 1'b1, 16'h0061, 16'h1001, -1);
      push_rsp(1, 1'b0, 16'h0000, -1);
      push_cmd(2, 1'b1, 16'h0062, 16'h2002, -1);
      push_rsp(2, 1'b0, 16'h0000, -1);
      req_valid = 4'b0110;
      repeat (2) wait_done(4'b0110);
`endif
      req_valid = 4'b0000;
      repeat (3) @(negedge pclk);
      chk("cmd_queue_empty", 32'(cq.size()), 32'd0);
      chk("rsp_queue_empty", 32'(rq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
      $finish;
   end

endmodule
